write_channel_scheduler: RTL and testbench

Sequences the shared AXI write path (AW, W, B) between two masters, S00 and S01, toward one downstream slave port.
- Arbitrates round-robin on AW requests.
- Locks the grant through the full AW, W-burst and B-response sequence, then releases it.
- Drives the route-enable and select signals for the AW/W/B muxes.
- Keeps the existing Channel_Granted / Channel_Request contract with the channel controller.
- Checks burst length against the captured AWLEN.

---
 rtl/axi_interconnect_pkg.sv | 16 +
 rtl/rr_arbiter_2.sv | 23 ++
 rtl/write_channel_scheduler.sv | 130 +++++++++++++
 tb/tb_write_channel_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_interconnect_pkg.sv
// Shared types and constants for the AXI interconnect write path.
package axi_interconnect_pkg;

  localparam int AXI_LEN_WIDTH = 8;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    AW_PHASE,
    W_PHASE,
    B_PHASE
  } wr_sched_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick: the pointer only matters when both request.
module rr_arbiter_2
  import axi_interconnect_pkg::*;
(
  input  logic       ptr_i,
  input  logic [1:0] req_i,
  output logic       gnt_valid_o,
  output logic       winner_o
);

  // Winner is the pointer on contention, otherwise the sole requester.
  always_comb begin
    gnt_valid_o = |req_i;
    winner_o    = ptr_i;
    case (req_i)
      2'b01:   winner_o = MASTER0;
      2'b10:   winner_o = MASTER1;
      2'b11:   winner_o = ptr_i;
      default: winner_o = ptr_i;
    endcase
  end

endmodule

// File: rtl/write_channel_scheduler.sv
// Sequences the shared AXI write path (AW, W, B) between two masters.
// The grant is locked from AW through the W burst to the B response.
module write_channel_scheduler
  import axi_interconnect_pkg::*;
#(
  parameter int Len_Width      = AXI_LEN_WIDTH,
  parameter int Master_ID_Size = 1
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      S00_AXI_awvalid,
  input  logic                      S01_AXI_awvalid,
  input  logic [Len_Width-1:0]      S00_AXI_awlen,
  input  logic [Len_Width-1:0]      S01_AXI_awlen,
  input  logic                      M_AXI_awvalid,
  input  logic                      M_AXI_awready,
  input  logic                      M_AXI_wvalid,
  input  logic                      M_AXI_wready,
  input  logic                      M_AXI_wlast,
  input  logic                      M_AXI_bvalid,
  input  logic                      M_AXI_bready,
  input  logic                      Channel_Granted,
  output logic                      Channel_Request,
  output logic [Master_ID_Size-1:0] Selected_Master,
  output logic                      AW_Route_En,
  output logic                      W_Route_En,
  output logic                      B_Route_En,
  output logic                      Busy,
  output logic                      Transaction_Done,
  output logic                      Burst_Error
);

  wr_sched_state_e            state_q, state_d;
  logic                       ptr_q, ptr_d;
  logic [Master_ID_Size-1:0]  sel_q, sel_d;
  logic [Len_Width-1:0]       len_q, len_d;
  logic [Len_Width-1:0]       beat_cnt_q, beat_cnt_d;

  logic gnt_valid;
  logic winner;
  logic aw_hs, w_hs, b_hs;

  assign aw_hs = M_AXI_awvalid & M_AXI_awready;
  assign w_hs  = M_AXI_wvalid & M_AXI_wready;
  assign b_hs  = M_AXI_bvalid & M_AXI_bready;

  rr_arbiter_2 u_arb (
    .ptr_i       (ptr_q),
    .req_i       ({S01_AXI_awvalid, S00_AXI_awvalid}),
    .gnt_valid_o (gnt_valid),
    .winner_o    (winner)
  );

  assign Channel_Request = Channel_Granted & (S00_AXI_awvalid | S01_AXI_awvalid)
                           & (state_q == IDLE);
  assign Busy            = (state_q != IDLE);
  assign Selected_Master = sel_q;

  // State, owner, captured length and beat counter registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      ptr_q      <= MASTER0;
      sel_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state, route enables and handshake-cycle pulses.
  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    sel_d            = sel_q;
    len_d            = len_q;
    beat_cnt_d       = beat_cnt_q;
    AW_Route_En      = 1'b0;
    W_Route_En       = 1'b0;
    B_Route_En       = 1'b0;
    Transaction_Done = 1'b0;
    Burst_Error      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Channel_Granted && gnt_valid) begin
          sel_d   = Master_ID_Size'(winner);
          len_d   = winner ? S01_AXI_awlen : S00_AXI_awlen;
          state_d = AW_PHASE;
        end
      end

      AW_PHASE: begin
        AW_Route_En = 1'b1;
        if (aw_hs) begin
          beat_cnt_d = '0;
          state_d    = W_PHASE;
        end
      end

      W_PHASE: begin
        W_Route_En = 1'b1;
        if (w_hs) begin
          // Saturate so an over-long burst never wraps into a false match.
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + Len_Width'(1);
          Burst_Error = (beat_cnt_q == len_q) ^ M_AXI_wlast;
          // WLAST always ends the burst, even if the count disagrees.
          if (M_AXI_wlast) state_d = B_PHASE;
        end
      end

      B_PHASE: begin
        B_Route_En = 1'b1;
        if (b_hs) begin
          Transaction_Done = 1'b1;
          ptr_d            = ~sel_q[0];
          state_d          = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_write_channel_scheduler.sv
// Self-checking bench for write_channel_scheduler (scoreboard of expected owners and error flags).
module tb_write_channel_scheduler;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic       S00_AXI_awvalid, S01_AXI_awvalid;
  logic [7:0] S00_AXI_awlen, S01_AXI_awlen;
  logic       M_AXI_awvalid, M_AXI_awready;
  logic       M_AXI_wvalid, M_AXI_wready, M_AXI_wlast;
  logic       M_AXI_bvalid, M_AXI_bready;
  logic       Channel_Granted;
  logic       Channel_Request;
  logic [0:0] Selected_Master;
  logic       AW_Route_En, W_Route_En, B_Route_En;
  logic       Busy, Transaction_Done, Burst_Error;

  int   n_cmp = 0;
  int   n_err = 0;
  logic model_ptr = 1'b0;
  logic model_sel = 1'b0;
  logic exp_sel_q[$];
  logic exp_berr_q[$];

  always #5 ACLK = ~ACLK;

  write_channel_scheduler #(.Len_Width(8), .Master_ID_Size(1)) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .S00_AXI_awvalid  (S00_AXI_awvalid),
    .S01_AXI_awvalid  (S01_AXI_awvalid),
    .S00_AXI_awlen    (S00_AXI_awlen),
    .S01_AXI_awlen    (S01_AXI_awlen),
    .M_AXI_awvalid    (M_AXI_awvalid),
    .M_AXI_awready    (M_AXI_awready),
    .M_AXI_wvalid     (M_AXI_wvalid),
    .M_AXI_wready     (M_AXI_wready),
    .M_AXI_wlast      (M_AXI_wlast),
    .M_AXI_bvalid     (M_AXI_bvalid),
    .M_AXI_bready     (M_AXI_bready),
    .Channel_Granted  (Channel_Granted),
    .Channel_Request  (Channel_Request),
    .Selected_Master  (Selected_Master),
    .AW_Route_En      (AW_Route_En),
    .W_Route_En       (W_Route_En),
    .B_Route_En       (B_Route_En),
    .Busy             (Busy),
    .Transaction_Done (Transaction_Done),
    .Burst_Error      (Burst_Error)
  );

  // Advance one clock; inputs are changed and outputs sampled mid-low-phase.
  task automatic tick;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle_inputs;
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 0;
    S00_AXI_awlen   = 0; S01_AXI_awlen   = 0;
    M_AXI_awvalid   = 0; M_AXI_awready   = 0;
    M_AXI_wvalid    = 0; M_AXI_wready    = 0; M_AXI_wlast = 0;
    M_AXI_bvalid    = 0; M_AXI_bready    = 0;
    Channel_Granted = 0;
  endtask

  // One full AW/W/B transaction with per-beat error expectations.
  task automatic run_txn(input logic v0, input logic v1, input logic [7:0] l0,
                         input logic [7:0] l1, input int nbeats, input bit toggle,
                         input bit drop_grant, input string tag);
    logic       winner, e_sel, e_berr, hold;
    logic [7:0] wlen;
    int         i, cyc;
    hold = v0 & v1;
    S00_AXI_awvalid = v0; S01_AXI_awvalid = v1;
    S00_AXI_awlen = l0;   S01_AXI_awlen = l1;
    Channel_Granted = 1;
    #1;
    n_cmp++;
    if (Channel_Request !== 1'b1) begin
      n_err++; $display("FAIL %s request: got %b expected 1", tag, Channel_Request);
    end
    winner = hold ? model_ptr : v1;
    wlen   = winner ? l1 : l0;
    exp_sel_q.push_back(winner);
    tick;
    e_sel = exp_sel_q.pop_front();
    n_cmp++;
    if (Selected_Master !== e_sel) begin
      n_err++; $display("FAIL %s owner: got %b expected %b", tag, Selected_Master, e_sel);
    end
    n_cmp++;
    if ({AW_Route_En, W_Route_En, B_Route_En, Busy, Channel_Request} !== 5'b10010) begin
      n_err++; $display("FAIL %s aw_phase: got %b expected 10010", tag,
                        {AW_Route_En, W_Route_En, B_Route_En, Busy, Channel_Request});
    end
    M_AXI_awvalid = 1; M_AXI_awready = 1;
    tick;
    M_AXI_awvalid = 0; M_AXI_awready = 0;
    if (!hold) begin S00_AXI_awvalid = 0; S01_AXI_awvalid = 0; end
    if (drop_grant) Channel_Granted = 0;
    #1;
    n_cmp++;
    if ({AW_Route_En, W_Route_En, B_Route_En} !== 3'b010) begin
      n_err++; $display("FAIL %s w_phase: got %b expected 010", tag,
                        {AW_Route_En, W_Route_En, B_Route_En});
    end
    i = 0; cyc = 0;
    while (i < nbeats && cyc < 4000) begin
      M_AXI_wvalid = 1;
      M_AXI_wready = toggle ? (cyc % 2 == 0) : 1'b1;
      M_AXI_wlast  = (i == nbeats - 1);
      #1;
      if (M_AXI_wready) begin
        exp_berr_q.push_back((8'(i) == wlen) ^ (i == nbeats - 1));
        e_berr = exp_berr_q.pop_front();
        i++;
      end else begin
        e_berr = 1'b0;
      end
      n_cmp++;
      if (Burst_Error !== e_berr) begin
        n_err++; $display("FAIL %s burst_err beat %0d: got %b expected %b", tag, i, Burst_Error, e_berr);
      end
      tick;
      cyc++;
    end
    n_cmp++;
    if (i != nbeats) begin
      n_err++; $display("FAIL %s beat_budget: got %0d expected %0d", tag, i, nbeats);
    end
    M_AXI_wvalid = 0; M_AXI_wready = 0; M_AXI_wlast = 0;
    #1;
    n_cmp++;
    if ({AW_Route_En, W_Route_En, B_Route_En, Channel_Request} !== 4'b0010) begin
      n_err++; $display("FAIL %s b_phase: got %b expected 0010", tag,
                        {AW_Route_En, W_Route_En, B_Route_En, Channel_Request});
    end
    M_AXI_bvalid = 1; M_AXI_bready = 1;
    #1;
    n_cmp++;
    if (Transaction_Done !== 1'b1) begin
      n_err++; $display("FAIL %s done: got %b expected 1", tag, Transaction_Done);
    end
    tick;
    M_AXI_bvalid = 0; M_AXI_bready = 0;
    if (!hold) begin S00_AXI_awvalid = 0; S01_AXI_awvalid = 0; end
    Channel_Granted = 1;
    #1;
    n_cmp++;
    if ({Transaction_Done, Busy, AW_Route_En, W_Route_En, B_Route_En} !== 5'b00000) begin
      n_err++; $display("FAIL %s idle_after: got %b expected 00000", tag,
                        {Transaction_Done, Busy, AW_Route_En, W_Route_En, B_Route_En});
    end
    model_ptr = ~winner;
    model_sel = winner;
    $display("txn %s: master=%0d len=%0d beats=%0d", tag, winner, wlen, nbeats);
  endtask

  task automatic test_reset;
    idle_inputs();
    ARESET = 1;
    tick; tick;
    ARESET = 0;
    #1;
    n_cmp++;
    if ({Busy, AW_Route_En, W_Route_En, B_Route_En, Transaction_Done, Burst_Error,
         Channel_Request, Selected_Master} !== 8'b0) begin
      n_err++; $display("FAIL reset_state: got %b expected 00000000",
                        {Busy, AW_Route_En, W_Route_En, B_Route_En, Transaction_Done,
                         Burst_Error, Channel_Request, Selected_Master});
    end
    model_ptr = 0; model_sel = 0;
    $display("txn reset: done");
  endtask

  task automatic test_single_burst;
    run_txn(1, 0, 8'd3, 8'd0, 4, 0, 0, "single_m0");
  endtask

  task automatic test_round_robin;
    for (int k = 0; k < 4; k++) run_txn(1, 1, 8'd1, 8'd2, (model_ptr ? 3 : 2), 0, 0, "rr");
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 0;
  endtask

  task automatic test_short_burst_error;
    run_txn(1, 0, 8'd1, 8'd0, 1, 0, 0, "early_wlast");
  endtask

  task automatic test_grant_low;
    S01_AXI_awvalid = 1; Channel_Granted = 0;
    #1;
    n_cmp++;
    if (Channel_Request !== 1'b0) begin
      n_err++; $display("FAIL grant_low request: got %b expected 0", Channel_Request);
    end
    tick; tick; tick;
    n_cmp++;
    if ({Busy, AW_Route_En, Selected_Master} !== {2'b00, model_sel}) begin
      n_err++; $display("FAIL grant_low idle: got %b expected %b",
                        {Busy, AW_Route_En, Selected_Master}, {2'b00, model_sel});
    end
    S01_AXI_awvalid = 0;
    $display("txn grant_low: held idle");
    run_txn(0, 1, 8'd0, 8'd2, 3, 0, 1, "grant_drop");
  endtask

  task automatic test_reset_mid;
    run_txn(1, 0, 8'd2, 8'd0, 3, 0, 0, "pre_abort");
    S01_AXI_awvalid = 1; S01_AXI_awlen = 8'd4; Channel_Granted = 1;
    tick;
    M_AXI_awvalid = 1; M_AXI_awready = 1;
    tick;
    M_AXI_awvalid = 0; M_AXI_awready = 0; S01_AXI_awvalid = 0;
    M_AXI_wvalid = 1; M_AXI_wready = 1;
    tick; tick;
    M_AXI_wvalid = 0; M_AXI_wready = 0;
    ARESET = 1;
    tick;
    ARESET = 0;
    M_AXI_bvalid = 1; M_AXI_bready = 1;
    #1;
    n_cmp++;
    if ({Busy, AW_Route_En, W_Route_En, B_Route_En, Transaction_Done, Selected_Master} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid: got %b expected 000000",
                        {Busy, AW_Route_En, W_Route_En, B_Route_En, Transaction_Done, Selected_Master});
    end
    M_AXI_bvalid = 0; M_AXI_bready = 0;
    exp_sel_q.delete(); exp_berr_q.delete();
    model_ptr = 0; model_sel = 0;
    $display("txn reset_mid: aborted");
    run_txn(1, 1, 8'd0, 8'd0, 1, 0, 0, "post_abort");
    S00_AXI_awvalid = 0; S01_AXI_awvalid = 0;
  endtask

  task automatic test_long_burst;
    run_txn(1, 0, 8'd255, 8'd0, 256, 1, 0, "len255");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESET = 1;
    idle_inputs();
    @(negedge ACLK);
    test_reset();
    test_single_burst();
    test_round_robin();
    test_short_burst_error();
    test_grant_low();
    test_reset_mid();
    test_long_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
